// File: rtl/rs_tag_allocator.sv
// Free-list controller for the ALU and load/store reservation stations.
// Each pool offers its lowest free entry to dispatch and reclaims entries on issue or flush.

module rs_tag_pool #(
    parameter int ENTRIES = 16,
    parameter int ROOT_W  = 4,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alloc,
    input  logic              rel_en,
    input  logic [ROOT_W-1:0] rel_tag,
    output logic [ROOT_W-1:0] free_tag,
    output logic              full,
    output logic              grant,
    output logic [CNT_W-1:0]  cnt,
    output logic              rel_err
);

    logic [ENTRIES-1:0] busy_q, busy_d;
    logic [ENTRIES-1:0] set_oh, clr_oh;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rel_hit, rel_act, rel_ok, do_flush;

    // Scan downwards so the lowest free index wins; stays 0 when the pool is full.
    always_comb begin
        free_tag = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_tag = ROOT_W'(i);
        end
    end

    assign full     = &busy_q;
    assign grant    = rdy & alloc & ~full & ~flush;
    assign do_flush = rdy & flush;
    assign rel_act  = rdy & ~flush & rel_en;

    // An out-of-range root matches no entry, so it reads as not-busy and is flagged.
    always_comb begin
        set_oh  = '0;
        clr_oh  = '0;
        rel_hit = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant && free_tag == ROOT_W'(i)) set_oh[i] = 1'b1;
            if (rel_tag == ROOT_W'(i)) begin
                clr_oh[i] = 1'b1;
                rel_hit   = busy_q[i];
            end
        end
    end

    assign rel_ok  = rel_act & rel_hit;
    assign rel_err = rel_act & ~rel_hit;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (do_flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            busy_d = (busy_q | set_oh) & ~(clr_oh & {ENTRIES{rel_ok}});
            cnt_d  = cnt_q + CNT_W'(grant) - CNT_W'(rel_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

module rs_tag_allocator #(
    parameter int ALU_ENTRIES = 16,
    parameter int LS_ENTRIES  = 16,
    parameter int ROOT_W      = 4,
    parameter int CNT_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alu_alloc,
    input  logic              ls_alloc,
    input  logic              alu_rel_en,
    input  logic [ROOT_W-1:0] alu_rel_tag,
    input  logic              ls_rel_en,
    input  logic [ROOT_W-1:0] ls_rel_tag,
    output logic [ROOT_W-1:0] alu_free_tag,
    output logic [ROOT_W-1:0] ls_free_tag,
    output logic              alu_full,
    output logic              ls_full,
    output logic              stall,
    output logic              alu_grant,
    output logic              ls_grant,
    output logic [CNT_W-1:0]  alu_cnt,
    output logic [CNT_W-1:0]  ls_cnt,
    output logic              err
);

    logic alu_rel_err, ls_rel_err;
    logic err_q, err_d;

    rs_tag_pool #(.ENTRIES(ALU_ENTRIES), .ROOT_W(ROOT_W), .CNT_W(CNT_W)) u_alu (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .alloc    (alu_alloc),
        .rel_en   (alu_rel_en),
        .rel_tag  (alu_rel_tag),
        .free_tag (alu_free_tag),
        .full     (alu_full),
        .grant    (alu_grant),
        .cnt      (alu_cnt),
        .rel_err  (alu_rel_err)
    );

    rs_tag_pool #(.ENTRIES(LS_ENTRIES), .ROOT_W(ROOT_W), .CNT_W(CNT_W)) u_ls (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .alloc    (ls_alloc),
        .rel_en   (ls_rel_en),
        .rel_tag  (ls_rel_tag),
        .free_tag (ls_free_tag),
        .full     (ls_full),
        .grant    (ls_grant),
        .cnt      (ls_cnt),
        .rel_err  (ls_rel_err)
    );

    // Sticky: only reset clears it, a flush does not.
    assign err_d = err_q | alu_rel_err | ls_rel_err;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err   = err_q;
    assign stall = alu_full | ls_full;

endmodule

// File: tb/tb_rs_tag_allocator.sv
// Bench for rs_tag_allocator: directed scenarios plus random traffic
// scored against a per-entry occupancy model of both pools.

module tb_rs_tag_allocator;

    logic       clk = 1'b0;
    logic       rst, rdy, flush;
    logic       alu_alloc, ls_alloc, alu_rel_en, ls_rel_en;
    logic [3:0] alu_rel_tag, ls_rel_tag;
    logic [3:0] alu_free_tag, ls_free_tag;
    logic       alu_full, ls_full, stall, alu_grant, ls_grant, err;
    logic [4:0] alu_cnt, ls_cnt;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Model: per pool, which entries are occupied; plus the sticky error.
    bit mb [2][16];
    bit merr;

    always #5 clk = ~clk;

    rs_tag_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .flush        (flush),
        .alu_alloc    (alu_alloc),
        .ls_alloc     (ls_alloc),
        .alu_rel_en   (alu_rel_en),
        .alu_rel_tag  (alu_rel_tag),
        .ls_rel_en    (ls_rel_en),
        .ls_rel_tag   (ls_rel_tag),
        .alu_free_tag (alu_free_tag),
        .ls_free_tag  (ls_free_tag),
        .alu_full     (alu_full),
        .ls_full      (ls_full),
        .stall        (stall),
        .alu_grant    (alu_grant),
        .ls_grant     (ls_grant),
        .alu_cnt      (alu_cnt),
        .ls_cnt       (ls_cnt),
        .err          (err)
    );

    function automatic int mfree(int p);
        for (int i = 0; i < 16; i++) if (!mb[p][i]) return i;
        return 16;
    endfunction

    function automatic int mcnt(int p);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(mb[p][i]);
        return n;
    endfunction

    // Drive one cycle of inputs, score the DUT against the model, then advance the model.
    task automatic tick(input logic aa, input logic la,
                        input logic are, input logic [3:0] at,
                        input logic lre, input logic [3:0] lt,
                        input logic fl, input logic rd, input logic rs);
        int af, lf, fr [2];
        logic eag, elg;
        logic al [2];
        logic re [2];
        logic [3:0] tg [2];
        @(posedge clk);
        #1;
        alu_alloc = aa; ls_alloc = la;
        alu_rel_en = are; alu_rel_tag = at;
        ls_rel_en = lre; ls_rel_tag = lt;
        flush = fl; rdy = rd; rst = rs;
        @(negedge clk);
        af  = mfree(0);
        lf  = mfree(1);
        eag = rd & aa & (af != 16) & ~fl;
        elg = rd & la & (lf != 16) & ~fl;
        if (mon_on) begin
            checks++;
            if (alu_free_tag !== 4'((af == 16) ? 0 : af) || alu_full !== (af == 16)) begin
                errors++;
                $display("FAIL alu_free: tag=%0d full=%0b required tag=%0d full=%0b",
                         alu_free_tag, alu_full, (af == 16) ? 0 : af, af == 16);
            end
            checks++;
            if (ls_free_tag !== 4'((lf == 16) ? 0 : lf) || ls_full !== (lf == 16)) begin
                errors++;
                $display("FAIL ls_free: tag=%0d full=%0b required tag=%0d full=%0b",
                         ls_free_tag, ls_full, (lf == 16) ? 0 : lf, lf == 16);
            end
            checks++;
            if (stall !== ((af == 16) || (lf == 16))) begin
                errors++;
                $display("FAIL stall: got %0b required %0b", stall, (af == 16) || (lf == 16));
            end
            checks++;
            if (alu_grant !== eag || ls_grant !== elg) begin
                errors++;
                $display("FAIL grants: alu=%0b ls=%0b required alu=%0b ls=%0b",
                         alu_grant, ls_grant, eag, elg);
            end
            checks++;
            if (alu_cnt !== 5'(mcnt(0)) || ls_cnt !== 5'(mcnt(1))) begin
                errors++;
                $display("FAIL popcount: alu_cnt=%0d ls_cnt=%0d required %0d %0d",
                         alu_cnt, ls_cnt, mcnt(0), mcnt(1));
            end
            checks++;
            if (err !== merr) begin
                errors++;
                $display("FAIL err_flag: got %0b required %0b", err, merr);
            end
        end
        // Advance the model to what the coming edge should produce.
        if (rs) begin
            for (int p = 0; p < 2; p++) for (int i = 0; i < 16; i++) mb[p][i] = 1'b0;
            merr = 1'b0;
        end else if (rd && fl) begin
            for (int p = 0; p < 2; p++) for (int i = 0; i < 16; i++) mb[p][i] = 1'b0;
        end else if (rd) begin
            fr[0] = af; fr[1] = lf;
            al[0] = aa; al[1] = la;
            re[0] = are; re[1] = lre;
            tg[0] = at; tg[1] = lt;
            for (int p = 0; p < 2; p++) begin
                if (re[p]) begin
                    if (!mb[p][tg[p]]) merr = 1'b1;
                    else mb[p][tg[p]] = 1'b0;
                end
                if (al[p] && fr[p] != 16) mb[p][fr[p]] = 1'b1;
            end
        end
    endtask

    task automatic idle();
        tick(0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0);
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 1);
        mon_on = 1'b1;
        idle();
        checks++;
        if (alu_free_tag !== 4'd0 || ls_free_tag !== 4'd0 || alu_cnt !== 5'd0 || ls_cnt !== 5'd0 ||
            stall !== 1'b0 || err !== 1'b0 || alu_grant !== 1'b0 || ls_grant !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: free=%0d/%0d cnt=%0d/%0d stall=%0b err=%0b grant=%0b/%0b required all 0",
                     alu_free_tag, ls_free_tag, alu_cnt, ls_cnt, stall, err, alu_grant, ls_grant);
        end
    endtask

    task automatic test_alu_fill();
        for (int i = 0; i < 16; i++) begin
            tick(1, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0);
            checks++;
            if (alu_free_tag !== 4'(i) || alu_grant !== 1'b1) begin
                errors++;
                $display("FAIL fill_order: cycle %0d tag=%0d grant=%0b required tag=%0d grant=1",
                         i, alu_free_tag, alu_grant, i);
            end
        end
        tick(1, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0);
        checks++;
        if (alu_full !== 1'b1 || stall !== 1'b1 || alu_cnt !== 5'd16 || alu_grant !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%0b stall=%0b cnt=%0d grant=%0b required 1 1 16 0",
                     alu_full, stall, alu_cnt, alu_grant);
        end
        idle();
        checks++;
        if (alu_cnt !== 5'd16 || alu_full !== 1'b1) begin
            errors++;
            $display("FAIL alloc_when_full: cnt=%0d full=%0b required 16 1", alu_cnt, alu_full);
        end
    endtask

    task automatic test_release_when_full();
        tick(1, 0, 1, 4'd5, 0, 4'd0, 0, 1, 0);
        checks++;
        if (alu_grant !== 1'b0) begin
            errors++;
            $display("FAIL rel_full_grant: got %0b required 0", alu_grant);
        end
        idle();
        checks++;
        if (alu_free_tag !== 4'd5 || alu_full !== 1'b0 || alu_cnt !== 5'd15) begin
            errors++;
            $display("FAIL rel_full_after: tag=%0d full=%0b cnt=%0d required 5 0 15",
                     alu_free_tag, alu_full, alu_cnt);
        end
    endtask

    task automatic test_alloc_release_same();
        tick(0, 0, 0, 4'd0, 0, 4'd0, 1, 1, 0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0);
        tick(1, 0, 1, 4'd1, 0, 4'd0, 0, 1, 0);
        checks++;
        if (alu_grant !== 1'b1 || alu_free_tag !== 4'd4) begin
            errors++;
            $display("FAIL same_cycle_grant: grant=%0b tag=%0d required 1 4", alu_grant, alu_free_tag);
        end
        idle();
        checks++;
        if (alu_free_tag !== 4'd1 || alu_cnt !== 5'd4) begin
            errors++;
            $display("FAIL same_cycle_after: tag=%0d cnt=%0d required 1 4", alu_free_tag, alu_cnt);
        end
    endtask

    task automatic test_flush();
        tick(0, 0, 0, 4'd0, 0, 4'd0, 1, 1, 0);
        for (int i = 0; i < 10; i++) tick(1, logic'(i < 3), 0, 4'd0, 0, 4'd0, 0, 1, 0);
        idle();
        checks++;
        if (alu_cnt !== 5'd10 || ls_cnt !== 5'd3) begin
            errors++;
            $display("FAIL flush_setup: cnt=%0d/%0d required 10/3", alu_cnt, ls_cnt);
        end
        tick(1, 1, 0, 4'd0, 0, 4'd0, 1, 1, 0);
        checks++;
        if (alu_grant !== 1'b0 || ls_grant !== 1'b0) begin
            errors++;
            $display("FAIL flush_grant: alu=%0b ls=%0b required 0 0", alu_grant, ls_grant);
        end
        idle();
        checks++;
        if (alu_cnt !== 5'd0 || ls_cnt !== 5'd0 || alu_free_tag !== 4'd0 || ls_free_tag !== 4'd0) begin
            errors++;
            $display("FAIL flush_after: cnt=%0d/%0d free=%0d/%0d required all 0",
                     alu_cnt, ls_cnt, alu_free_tag, ls_free_tag);
        end
    endtask

    task automatic test_rdy();
        tick(1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
        checks++;
        if (alu_grant !== 1'b0) begin
            errors++;
            $display("FAIL rdy_low_grant: got %0b required 0", alu_grant);
        end
        tick(1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
        checks++;
        if (alu_cnt !== 5'd0 || alu_free_tag !== 4'd0) begin
            errors++;
            $display("FAIL rdy_low_frozen: cnt=%0d tag=%0d required 0 0", alu_cnt, alu_free_tag);
        end
        tick(1, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0);
        checks++;
        if (alu_grant !== 1'b1) begin
            errors++;
            $display("FAIL rdy_back_grant: got %0b required 1", alu_grant);
        end
        idle();
        checks++;
        if (alu_cnt !== 5'd1 || alu_free_tag !== 4'd1) begin
            errors++;
            $display("FAIL rdy_back_after: cnt=%0d tag=%0d required 1 1", alu_cnt, alu_free_tag);
        end
    endtask

    task automatic test_ls_err();
        tick(0, 0, 0, 4'd0, 1, 4'd7, 0, 1, 0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_early: got %0b required 0", err);
        end
        idle();
        checks++;
        if (err !== 1'b1 || ls_cnt !== 5'd0) begin
            errors++;
            $display("FAIL err_set: err=%0b ls_cnt=%0d required 1 0", err, ls_cnt);
        end
        tick(0, 0, 0, 4'd0, 0, 4'd0, 1, 1, 0);
        idle();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_after_flush: got %0b required 1", err);
        end
    endtask

    task automatic test_random();
        tick(0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 1);
        for (int n = 0; n < 3000; n++) begin
            tick(logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 99) < 55),
                 logic'($urandom_range(0, 99) < 40), 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 99) < 40), 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 7) != 0),
                 logic'($urandom_range(0, 499) == 0));
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        alu_alloc = 1'b0; ls_alloc = 1'b0;
        alu_rel_en = 1'b0; alu_rel_tag = 4'd0;
        ls_rel_en = 1'b0; ls_rel_tag = 4'd0;
        test_reset();
        test_alu_fill();
        test_release_when_full();
        test_alloc_release_same();
        test_flush();
        test_rdy();
        test_ls_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
